r5p_mdu_seq: RTL and testbench

//  Iterative multiply/divide sequencer for the RV32M/RV64M ops (MUL*, DIV*, REM*).

---
 rtl/r5p_mdu_seq_if.sv | 31 +++
 rtl/r5p_mdu_seq.sv | 195 +++++++++++++++++++
 tb/tb_r5p_mdu_seq.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/r5p_mdu_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : r5p_mdu_seq_if
//  Brief    : Request/response/kill bundle between decode, writeback and MDU.
//  Revision : 1.0
// ============================================================================
interface r5p_mdu_seq_if #(
    parameter int XLEN = 32
) ();
    logic            req_vld;
    logic            req_rdy;
    logic [2:0]      req_f3;
    logic [XLEN-1:0] req_rs1;
    logic [XLEN-1:0] req_rs2;
    logic            kill;
    logic            rsp_vld;
    logic            rsp_rdy;
    logic [XLEN-1:0] rsp_rd;
    logic            busy;

    modport master (
        output req_vld, req_f3, req_rs1, req_rs2, kill, rsp_rdy,
        input  req_rdy, rsp_vld, rsp_rd, busy
    );

    modport slave (
        input  req_vld, req_f3, req_rs1, req_rs2, kill, rsp_rdy,
        output req_rdy, rsp_vld, rsp_rd, busy
    );
endinterface
`default_nettype wire

// File: rtl/r5p_mdu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : r5p_mdu_seq
//  Brief    : Iterative RV32M/RV64M multiply/divide sequencer, one bit per cycle.
//  Revision : 1.0
// ============================================================================
module r5p_mdu_seq #(
    parameter int XLEN = 32
) (
    input  wire logic        clk,
    input  wire logic        rst,
    r5p_mdu_seq_if.slave     bus
);
    localparam int              c_CW       = $clog2(XLEN);
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(XLEN - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
    localparam logic [XLEN-1:0] c_MIN      = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [2:0]      r_f3;
    logic            r_neg;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_opd;
    logic [c_CW-1:0] r_cnt;
    logic            r_req_rdy;
    logic            r_busy;
    logic            r_rsp_vld;
    logic [XLEN-1:0] r_rsp_rd;

    // ------------------------------------------------------------------
    // Accept-time decode: operand magnitudes, result sign, special cases
    // ------------------------------------------------------------------
    logic            w_req_div;
    logic            w_s1;
    logic            w_s2;
    logic            w_n1;
    logic            w_n2;
    logic [XLEN-1:0] w_abs1;
    logic [XLEN-1:0] w_abs2;
    logic            w_neg_acc;
    logic            w_div0;
    logic            w_ovf;
    logic [XLEN-1:0] w_spec_rd;

    always_comb begin
        w_req_div = bus.req_f3[2];
        // MUL/MULH/MULHSU treat rs1 as signed, MUL/MULH rs2; DIV/REM both
        w_s1      = w_req_div ? ~bus.req_f3[0] : (bus.req_f3[1:0] != 2'b11);
        w_s2      = w_req_div ? ~bus.req_f3[0] : ~bus.req_f3[1];
        w_n1      = w_s1 & bus.req_rs1[XLEN-1];
        w_n2      = w_s2 & bus.req_rs2[XLEN-1];
        w_abs1    = w_n1 ? -bus.req_rs1 : bus.req_rs1;
        w_abs2    = w_n2 ? -bus.req_rs2 : bus.req_rs2;
        w_neg_acc = (w_req_div && bus.req_f3[1]) ? w_n1 : (w_n1 ^ w_n2);
        w_div0    = w_req_div && (bus.req_rs2 == '0);
        w_ovf     = w_req_div && !bus.req_f3[0] && (bus.req_rs1 == c_MIN) &&
                    (bus.req_rs2 == '1);
        w_spec_rd = '0;
        if (w_div0) begin
            w_spec_rd = bus.req_f3[1] ? bus.req_rs1 : '1;
        end else if (w_ovf) begin
            w_spec_rd = bus.req_f3[1] ? '0 : bus.req_rs1;
        end
    end

    // ------------------------------------------------------------------
    // Shared XLEN+1 bit adder: shift-add for multiply, trial subtract for
    // divide. For divide the carry-out means "no borrow", i.e. keep.
    // ------------------------------------------------------------------
    logic              w_div_op;
    logic [XLEN:0]     w_add_a;
    logic [XLEN:0]     w_add_b;
    logic [XLEN+1:0]   w_sum;
    logic              w_keep;
    logic [XLEN-1:0]   w_nhi;
    logic [XLEN-1:0]   w_nlo;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_div_raw;
    logic [XLEN-1:0]   w_fin;

    always_comb begin
        w_div_op = r_f3[2];
        w_add_a  = w_div_op ? {r_hi, r_lo[XLEN-1]} : {1'b0, r_hi};
        if (w_div_op) begin
            w_add_b = ~{1'b0, r_opd};
        end else begin
            w_add_b = r_lo[0] ? {1'b0, r_opd} : '0;
        end
        w_sum  = {1'b0, w_add_a} + {1'b0, w_add_b} + {{(XLEN+1){1'b0}}, w_div_op};
        w_keep = w_sum[XLEN+1];

        if (w_div_op) begin
            w_nhi = w_keep ? w_sum[XLEN-1:0] : w_add_a[XLEN-1:0];
            w_nlo = {r_lo[XLEN-2:0], w_keep};
        end else begin
            w_nhi = w_sum[XLEN:1];
            w_nlo = {w_sum[0], r_lo[XLEN-1:1]};
        end

        // Sign fix-up and result selection applied to the final iteration
        w_prod    = r_neg ? -{w_nhi, w_nlo} : {w_nhi, w_nlo};
        w_div_raw = r_f3[1] ? w_nhi : w_nlo;
        if (w_div_op) begin
            w_fin = r_neg ? -w_div_raw : w_div_raw;
        end else if (r_f3[1:0] == 2'b00) begin
            w_fin = w_prod[XLEN-1:0];
        end else begin
            w_fin = w_prod[2*XLEN-1:XLEN];
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM; kill overrides every transition
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_f3      <= '0;
            r_neg     <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_opd     <= '0;
            r_cnt     <= '0;
            r_req_rdy <= 1'b1;
            r_busy    <= 1'b0;
            r_rsp_vld <= 1'b0;
            r_rsp_rd  <= '0;
        end else if (bus.kill) begin
            r_state   <= S_IDLE;
            r_req_rdy <= 1'b1;
            r_busy    <= 1'b0;
            r_rsp_vld <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_vld) begin
                        r_f3      <= bus.req_f3;
                        r_neg     <= w_neg_acc;
                        r_cnt     <= '0;
                        r_req_rdy <= 1'b0;
                        r_busy    <= 1'b1;
                        if (w_div0 || w_ovf) begin
                            r_rsp_rd  <= w_spec_rd;
                            r_rsp_vld <= 1'b1;
                            r_state   <= S_DONE;
                        end else begin
                            r_hi    <= '0;
                            r_lo    <= w_req_div ? w_abs1 : w_abs2;
                            r_opd   <= w_req_div ? w_abs2 : w_abs1;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_hi  <= w_nhi;
                    r_lo  <= w_nlo;
                    r_cnt <= r_cnt + c_CNT_ONE;
                    if (r_cnt == c_CNT_LAST) begin
                        r_rsp_rd  <= w_fin;
                        r_rsp_vld <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.rsp_rdy) begin
                        r_rsp_vld <= 1'b0;
                        r_busy    <= 1'b0;
                        r_req_rdy <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_req_rdy <= 1'b1;
                    r_busy    <= 1'b0;
                    r_rsp_vld <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_rdy = r_req_rdy;
    assign bus.busy    = r_busy;
    assign bus.rsp_vld = r_rsp_vld;
    assign bus.rsp_rd  = r_rsp_rd;

endmodule
`default_nettype wire

// File: tb/tb_r5p_mdu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_r5p_mdu_seq
//  Brief    : Directed and randomized checks of r5p_mdu_seq at XLEN=32 and 64.
//  Revision : 1.0
// ============================================================================
module tb_r5p_mdu_seq;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    r5p_mdu_seq_if #(.XLEN(32)) if32 ();
    r5p_mdu_seq_if #(.XLEN(64)) if64 ();

    r5p_mdu_seq #(.XLEN(32)) dut32 (.clk(clk), .rst(rst), .bus(if32));
    r5p_mdu_seq #(.XLEN(64)) dut64 (.clk(clk), .rst(rst), .bus(if64));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: full-precision integer arithmetic on sign/zero-extended operands
    function automatic logic [63:0] ref_mdu(input int xl, input logic [2:0] f3,
                                            input logic [63:0] a, input logic [63:0] b);
        logic signed [129:0] ua, ub, sa, sb, p, two_xl;
        logic [63:0]         m;
        m      = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        ua     = $signed({66'd0, a & m});
        ub     = $signed({66'd0, b & m});
        two_xl = 130'sd1 <<< xl;
        sa     = a[xl-1] ? ua - two_xl : ua;
        sb     = b[xl-1] ? ub - two_xl : ub;
        p      = '0;
        case (f3)
            3'b000: p = ua * ub;
            3'b001: p = (sa * sb) >>> xl;
            3'b010: p = (sa * ub) >>> xl;
            3'b011: p = (ua * ub) >>> xl;
            3'b100: p = (ub == 0) ? $signed({66'd0, m}) : sa / sb;
            3'b101: p = (ub == 0) ? $signed({66'd0, m}) : ua / ub;
            3'b110: p = (ub == 0) ? ua : sa % sb;
            default: p = (ub == 0) ? ua : ua % ub;
        endcase
        return p[63:0] & m;
    endfunction

    function automatic int ref_lat(input int xl, input logic [2:0] f3,
                                   input logic [63:0] a, input logic [63:0] b);
        logic [63:0] m, mn;
        m  = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        mn = 64'd1 << (xl - 1);
        if (f3[2] && ((b & m) == 0)) return 1;
        if (f3[2] && !f3[0] && ((a & m) == mn) && ((b & m) == m)) return 1;
        return xl + 1;
    endfunction

    function automatic logic [63:0] rnd_val(input int xl);
        logic [63:0] m, v;
        m = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = '1;
            2:       v = 64'd1 << (xl - 1);
            3:       v = 64'($urandom_range(0, 20));
            4:       v = -64'($urandom_range(1, 20));
            default: v = {$urandom, $urandom};
        endcase
        return v & m;
    endfunction

    function automatic logic get_rdy(input bit w64);
        return w64 ? if64.req_rdy : if32.req_rdy;
    endfunction
    function automatic logic get_vld(input bit w64);
        return w64 ? if64.rsp_vld : if32.rsp_vld;
    endfunction
    function automatic logic get_busy(input bit w64);
        return w64 ? if64.busy : if32.busy;
    endfunction
    function automatic logic [63:0] get_rd(input bit w64);
        return w64 ? if64.rsp_rd : {32'd0, if32.rsp_rd};
    endfunction

    task automatic drive_req(input bit w64, input logic vld, input logic [2:0] f3,
                             input logic [63:0] a, input logic [63:0] b);
        if (w64) begin
            if64.req_vld = vld; if64.req_f3 = f3; if64.req_rs1 = a; if64.req_rs2 = b;
        end else begin
            if32.req_vld = vld; if32.req_f3 = f3; if32.req_rs1 = a[31:0]; if32.req_rs2 = b[31:0];
        end
    endtask

    task automatic set_rsp_rdy(input bit w64, input logic v);
        if (w64) if64.rsp_rdy = v; else if32.rsp_rdy = v;
    endtask

    task automatic set_kill(input bit w64, input logic v);
        if (w64) if64.kill = v; else if32.kill = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, scramble the request after accept, wait (bounded) for the
    // response, hold it for 'hold' cycles, then accept it. lat counts cycles
    // after the accept edge until rsp_vld is first observed (1 = next cycle).
    task automatic run_op(input bit w64, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] b, input int hold,
                          output logic [63:0] res, output int lat);
        int guard;
        guard = 0;
        while (!get_rdy(w64) && guard < 200) begin
            tick();
            guard++;
        end
        drive_req(w64, 1'b1, f3, a, b);
        tick();
        drive_req(w64, 1'b0, 3'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
        lat = 1;
        while (!get_vld(w64) && lat < 200) begin
            tick();
            lat++;
        end
        if (!get_vld(w64)) check_val("rsp_timeout", 64'(get_vld(w64)), 64'd1);
        res = get_rd(w64);
        repeat (hold) tick();
        set_rsp_rdy(w64, 1'b1);
        tick();
        set_rsp_rdy(w64, 1'b0);
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    initial begin
        vec_t        dv[12];
        logic [63:0] res;
        int          lat;
        int          hits;

        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        drive_req(1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
        drive_req(1'b1, 1'b0, 3'd0, 64'd0, 64'd0);
        set_kill(1'b0, 1'b0); set_kill(1'b1, 1'b0);
        set_rsp_rdy(1'b0, 1'b0); set_rsp_rdy(1'b1, 1'b0);
        repeat (3) tick();

        check_val("rst_rsp_vld", 64'(if32.rsp_vld), 64'd0);
        check_val("rst_rsp_rd",  64'(if32.rsp_rd),  64'd0);
        check_val("rst_busy",    64'(if32.busy),    64'd0);
        check_val("rst_req_rdy", 64'(if32.req_rdy), 64'd1);
        rst = 1'b0;
        tick();

        dv[0]  = '{3'b000, 64'd7,          64'hFFFF_FFFD, 64'hFFFF_FFEB, 33};
        dv[1]  = '{3'b001, 64'h8000_0000,  64'h8000_0000, 64'h4000_0000, 33};
        dv[2]  = '{3'b011, 64'hFFFF_FFFF,  64'hFFFF_FFFF, 64'hFFFF_FFFE, 33};
        dv[3]  = '{3'b010, 64'hFFFF_FFFF,  64'hFFFF_FFFF, 64'hFFFF_FFFF, 33};
        dv[4]  = '{3'b100, 64'hFFFF_FFF9,  64'd2,         64'hFFFF_FFFD, 33};
        dv[5]  = '{3'b110, 64'hFFFF_FFF9,  64'd2,         64'hFFFF_FFFF, 33};
        dv[6]  = '{3'b101, 64'd100,        64'd7,         64'd14,        33};
        dv[7]  = '{3'b111, 64'd100,        64'd7,         64'd2,         33};
        dv[8]  = '{3'b100, 64'd5,          64'd0,         64'hFFFF_FFFF, 1};
        dv[9]  = '{3'b111, 64'd5,          64'd0,         64'd5,         1};
        dv[10] = '{3'b100, 64'h8000_0000,  64'hFFFF_FFFF, 64'h8000_0000, 1};
        dv[11] = '{3'b110, 64'h8000_0000,  64'hFFFF_FFFF, 64'd0,         1};
        for (int i = 0; i < 12; i++) begin
            run_op(1'b0, dv[i].f3, dv[i].a, dv[i].b, 0, res, lat);
            check_val($sformatf("dir%0d_rd", i), res, dv[i].exp);
            check_val($sformatf("dir%0d_lat", i), 64'(lat), 64'(dv[i].lat));
        end

        // Backpressure: response held, new request ignored while DONE
        drive_req(1'b0, 1'b1, 3'b101, 64'd100, 64'd7);
        tick();
        drive_req(1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
        hits = 0;
        while (!if32.rsp_vld && hits < 200) begin
            tick();
            hits++;
        end
        drive_req(1'b0, 1'b1, 3'b000, 64'd3, 64'd3);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_val("bp_vld", 64'(if32.rsp_vld), 64'd1);
            check_val("bp_rd",  64'(if32.rsp_rd),  64'd14);
            check_val("bp_rdy", 64'(if32.req_rdy), 64'd0);
        end
        drive_req(1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
        set_rsp_rdy(1'b0, 1'b1);
        tick();
        set_rsp_rdy(1'b0, 1'b0);
        check_val("bp_idle_busy", 64'(if32.busy),    64'd0);
        check_val("bp_idle_vld",  64'(if32.rsp_vld), 64'd0);

        // Kill during the fifth CALC cycle
        drive_req(1'b0, 1'b1, 3'b000, 64'd1234, 64'd5678);
        tick();
        drive_req(1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
        repeat (4) tick();
        check_val("kill_pre_busy", 64'(if32.busy), 64'd1);
        set_kill(1'b0, 1'b1);
        tick();
        set_kill(1'b0, 1'b0);
        check_val("kill_busy", 64'(if32.busy),    64'd0);
        check_val("kill_vld",  64'(if32.rsp_vld), 64'd0);
        check_val("kill_rdy",  64'(if32.req_rdy), 64'd1);
        hits = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (if32.rsp_vld) hits++;
        end
        check_val("kill_no_rsp", 64'(hits), 64'd0);
        run_op(1'b0, 3'b000, 64'd1234, 64'd5678, 0, res, lat);
        check_val("post_kill_rd", res, 64'd7_006_652);

        // Kill in IDLE blocks the accept; kill in DONE drops the response
        drive_req(1'b0, 1'b1, 3'b000, 64'd2, 64'd2);
        set_kill(1'b0, 1'b1);
        tick();
        drive_req(1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
        set_kill(1'b0, 1'b0);
        check_val("kill_idle_busy", 64'(if32.busy), 64'd0);
        drive_req(1'b0, 1'b1, 3'b100, 64'd5, 64'd0);
        tick();
        drive_req(1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
        check_val("kdone_pre_vld", 64'(if32.rsp_vld), 64'd1);
        set_kill(1'b0, 1'b1);
        tick();
        set_kill(1'b0, 1'b0);
        check_val("kdone_vld", 64'(if32.rsp_vld), 64'd0);

        // Asynchronous reset between edges in the middle of CALC
        drive_req(1'b0, 1'b1, 3'b001, 64'h1234_5678, 64'h9ABC_DEF0);
        tick();
        drive_req(1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        check_val("arst_vld",  64'(if32.rsp_vld), 64'd0);
        check_val("arst_rd",   64'(if32.rsp_rd),  64'd0);
        check_val("arst_busy", 64'(if32.busy),    64'd0);
        check_val("arst_rdy",  64'(if32.req_rdy), 64'd1);
        #2 rst = 1'b0;
        tick();
        run_op(1'b0, 3'b110, 64'hFFFF_FF9C, 64'd7, 0, res, lat);
        check_val("post_arst_rd", res, 64'hFFFF_FFFE);

        // Randomized regression against the reference model, both widths
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 60; i++) begin
                int          xl;
                logic [2:0]  f3;
                logic [63:0] a, b;
                xl = (w == 1) ? 64 : 32;
                f3 = 3'($urandom_range(0, 7));
                a  = rnd_val(xl);
                b  = rnd_val(xl);
                run_op(w == 1, f3, a, b, $urandom_range(0, 3), res, lat);
                check_val($sformatf("rnd%0d_f%0d_%h_%h", xl, f3, a, b), res, ref_mdu(xl, f3, a, b));
                check_val($sformatf("rnd%0d_lat", xl), 64'(lat), 64'(ref_lat(xl, f3, a, b)));
            end
        end
        check_val("end_busy64", 64'(get_busy(1'b1)), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
